tone_nco: RTL and testbench

Phase-accumulator tone generator that consumes the 32-bit `freq_step` word produced by the distance-to-frequency-step lookup stage and drives the buzzer pin with a 50 % square wave. Each cycle it adds an active step to a 32-bit accumulator and exports the accumulator MSB as the tone. New step values are adopted only at an accumulator wrap, so the output is glitch-free. An optional beep cadence gates the tone on and off.

---
 rtl/tone_pkg.sv | 10 +
 rtl/tone_nco_beep_gate.sv | 68 ++++++
 rtl/tone_nco.sv | 83 ++++++++
 tb/tb_tone_nco.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared types and defaults for the tone NCO and its beep cadence gate.
package tone_pkg;

  localparam int unsigned ACC_WIDTH_DEFAULT = 32;

  typedef enum logic {BEEP_ON, BEEP_OFF} beep_state_t;

  typedef logic [31:0] step_t;

endpackage

// File: rtl/tone_nco_beep_gate.sv
// Beep cadence: ON for ON_CYCLES running cycles, OFF for OFF_CYCLES, repeating.
// Only built into tone_nco when TONE_BEEP_EN is defined.
module beep_gate
  import tone_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = 5_000_000,
  parameter int unsigned OFF_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clr,
  output logic gate
);

  localparam int unsigned MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] OFF_LAST = CW'(OFF_CYCLES - 1);

  beep_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BEEP_ON;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clr) begin
      state_d = BEEP_ON;
      cnt_d   = '0;
    end else if (run) begin
      case (state_q)
        BEEP_ON: begin
          if (cnt_q == ON_LAST) begin
            state_d = BEEP_OFF;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        BEEP_OFF: begin
          if (cnt_q == OFF_LAST) begin
            state_d = BEEP_ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = BEEP_ON;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign gate = (state_q == BEEP_ON);

endmodule

// File: rtl/tone_nco.sv
// Phase-accumulator square-wave tone generator; step changes land only at a wrap.
// Optional beep cadence gating is compiled in with TONE_BEEP_EN.
module tone_nco
  import tone_pkg::*;
#(
  parameter int unsigned ACC_WIDTH       = ACC_WIDTH_DEFAULT,
  parameter int unsigned BEEP_ON_CYCLES  = 5_000_000,
  parameter int unsigned BEEP_OFF_CYCLES = 5_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [ACC_WIDTH-1:0] freq_step,
  output logic                 tone_out,
  output logic                 wrap,
  output logic [ACC_WIDTH-1:0] phase
);

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] step_q, step_d;
  logic                 wrap_q, wrap_d;
  logic                 tone_q, tone_d;
  logic [ACC_WIDTH:0]   sum_w;
  logic                 carry_w;
  logic                 step_zero_w;
  logic                 gate_w;

  if (BEEP_ON_CYCLES == 0 || BEEP_OFF_CYCLES == 0) begin : g_bad_cadence
    $error("tone_nco: beep cadence lengths must be nonzero");
  end

`ifdef TONE_BEEP_EN
  beep_gate #(
    .ON_CYCLES  (BEEP_ON_CYCLES),
    .OFF_CYCLES (BEEP_OFF_CYCLES)
  ) u_beep_gate (
    .clk   (clk),
    .reset (reset),
    .run   (enable & ~step_zero_w),
    .clr   (~enable),
    .gate  (gate_w)
  );
`else
  assign gate_w = 1'b1;
`endif

  assign sum_w       = {1'b0, acc_q} + {1'b0, step_q};
  assign carry_w     = sum_w[ACC_WIDTH];
  assign step_zero_w = (step_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      step_q <= '0;
      wrap_q <= 1'b0;
      tone_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
      tone_q <= tone_d;
    end
  end

  // The add always uses the old step; a reload on carry only affects the next period.
  always_comb begin
    acc_d  = '0;
    step_d = '0;
    wrap_d = 1'b0;
    tone_d = 1'b0;
    if (enable) begin
      acc_d  = sum_w[ACC_WIDTH-1:0];
      wrap_d = carry_w;
      tone_d = sum_w[ACC_WIDTH-1] & gate_w;
      step_d = (carry_w || step_zero_w) ? freq_step : step_q;
    end
  end

  assign phase    = acc_q;
  assign wrap     = wrap_q;
  assign tone_out = tone_q;

endmodule

// File: tb/tb_tone_nco.sv
// Directed self-checking bench for tone_nco (beep cadence checked when TONE_BEEP_EN is defined).
module tb_tone_nco;
  import tone_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  step_t        freq_step;
  logic         tone_out;
  logic         wrap;
  logic [W-1:0] phase;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tone_nco #(
    .ACC_WIDTH       (W),
    .BEEP_ON_CYCLES  (32),
    .BEEP_OFF_CYCLES (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .freq_step (freq_step),
    .tone_out  (tone_out),
    .wrap      (wrap),
    .phase     (phase)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    enable    = 1'b0;
    freq_step = '0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    enable    = 1'b0;
    freq_step = '0;
    #1;
    checks++; if (phase !== '0) begin errors++; $display("FAIL reset_phase: got %h expected 0", phase); end
    checks++; if (tone_out !== 1'b0) begin errors++; $display("FAIL reset_tone: got %b expected 0", tone_out); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b expected 0", wrap); end
    enable    = 1'b1;
    freq_step = 32'h1000_0000;
    repeat (3) tick();
    checks++; if (phase !== '0) begin errors++; $display("FAIL reset_hold_phase: got %h expected 0", phase); end
    reset = 1'b0;
    enable = 1'b0;
    tick();
  endtask

  task automatic test_basic_tone();
    step_t exp_p;
    logic  exp_w;
    apply_reset();
    enable    = 1'b1;
    freq_step = 32'h1000_0000;
    for (int i = 1; i <= 33; i++) begin
      tick();
      exp_p = step_t'(i - 1) << 28;
      exp_w = (i >= 17) && ((i - 1) % 16 == 0);
      checks++; if (phase !== exp_p) begin errors++; $display("FAIL basic_phase[%0d]: got %h expected %h", i, phase, exp_p); end
      checks++; if (tone_out !== exp_p[31]) begin errors++; $display("FAIL basic_tone[%0d]: got %b expected %b", i, tone_out, exp_p[31]); end
      checks++; if (wrap !== exp_w) begin errors++; $display("FAIL basic_wrap[%0d]: got %b expected %b", i, wrap, exp_w); end
    end
  endtask

  task automatic test_mid_change();
    step_t exp_p;
    logic  exp_w;
    apply_reset();
    enable    = 1'b1;
    freq_step = 32'h1000_0000;
    repeat (6) tick();
    checks++; if (phase !== 32'h5000_0000) begin errors++; $display("FAIL mid_start: got %h expected 50000000", phase); end
    freq_step = 32'h2000_0000;
    for (int j = 1; j <= 27; j++) begin
      tick();
      exp_p = (j <= 11) ? (step_t'(5 + j) << 28) : (step_t'(j - 11) << 29);
      exp_w = (j == 11) || (j == 19) || (j == 27);
      checks++; if (phase !== exp_p) begin errors++; $display("FAIL mid_phase[%0d]: got %h expected %h", j, phase, exp_p); end
      checks++; if (tone_out !== exp_p[31]) begin errors++; $display("FAIL mid_tone[%0d]: got %b expected %b", j, tone_out, exp_p[31]); end
      checks++; if (wrap !== exp_w) begin errors++; $display("FAIL mid_wrap[%0d]: got %b expected %b", j, wrap, exp_w); end
    end
  endtask

  task automatic test_zero_step();
    step_t exp_p;
    logic  exp_w;
    apply_reset();
    enable    = 1'b1;
    freq_step = 32'h1000_0000;
    repeat (4) tick();
    freq_step = '0;
    for (int j = 1; j <= 18; j++) begin
      tick();
      exp_p = (j <= 13) ? (step_t'(3 + j) << 28) : '0;
      exp_w = (j == 13);
      checks++; if (phase !== exp_p) begin errors++; $display("FAIL zero_phase[%0d]: got %h expected %h", j, phase, exp_p); end
      checks++; if (wrap !== exp_w) begin errors++; $display("FAIL zero_wrap[%0d]: got %b expected %b", j, wrap, exp_w); end
    end
    freq_step = 32'h4000_0000;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp_p = (k == 1) ? '0 : (step_t'(k - 1) << 30);
      exp_w = (k == 5);
      checks++; if (phase !== exp_p) begin errors++; $display("FAIL restart_phase[%0d]: got %h expected %h", k, phase, exp_p); end
      checks++; if (tone_out !== exp_p[31]) begin errors++; $display("FAIL restart_tone[%0d]: got %b expected %b", k, tone_out, exp_p[31]); end
      checks++; if (wrap !== exp_w) begin errors++; $display("FAIL restart_wrap[%0d]: got %b expected %b", k, wrap, exp_w); end
    end
    // Freeze at a nonzero phase with the MSB set: 0xC000_0000 wraps to 0x8000_0000.
    apply_reset();
    enable    = 1'b1;
    freq_step = 32'hC000_0000;
    tick();
    freq_step = '0;
    tick();
    checks++; if (phase !== 32'hC000_0000) begin errors++; $display("FAIL freeze_pre: got %h expected c0000000", phase); end
    tick();
    checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL freeze_wrap: got %b expected 1", wrap); end
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++; if (phase !== 32'h8000_0000) begin errors++; $display("FAIL freeze_phase[%0d]: got %h expected 80000000", k, phase); end
      checks++; if (tone_out !== 1'b1) begin errors++; $display("FAIL freeze_tone[%0d]: got %b expected 1", k, tone_out); end
      checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL freeze_nowrap[%0d]: got %b expected 0", k, wrap); end
    end
  endtask

  task automatic test_enable_carry();
    apply_reset();
    enable    = 1'b1;
    freq_step = 32'h1000_0000;
    repeat (16) tick();
    checks++; if (phase !== 32'hF000_0000) begin errors++; $display("FAIL en_pre: got %h expected f0000000", phase); end
    enable = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++; if (phase !== '0) begin errors++; $display("FAIL en_off_phase[%0d]: got %h expected 0", k, phase); end
      checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL en_off_wrap[%0d]: got %b expected 0", k, wrap); end
      checks++; if (tone_out !== 1'b0) begin errors++; $display("FAIL en_off_tone[%0d]: got %b expected 0", k, tone_out); end
    end
    enable = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++; if (phase !== (step_t'(k - 1) << 28)) begin errors++; $display("FAIL en_restart[%0d]: got %h expected %h", k, phase, step_t'(k - 1) << 28); end
    end
  endtask

  task automatic test_async_reset(input int n);
    step_t exp_p;
    apply_reset();
    enable    = 1'b1;
    freq_step = 32'h1000_0000;
    repeat (n) tick();
    exp_p = step_t'(n - 1) << 28;
    checks++; if (phase !== exp_p) begin errors++; $display("FAIL arst_pre[%0d]: got %h expected %h", n, phase, exp_p); end
    checks++; if (tone_out !== exp_p[31]) begin errors++; $display("FAIL arst_pre_tone[%0d]: got %b expected %b", n, tone_out, exp_p[31]); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (phase !== '0) begin errors++; $display("FAIL arst_phase[%0d]: got %h expected 0", n, phase); end
    checks++; if (tone_out !== 1'b0) begin errors++; $display("FAIL arst_tone[%0d]: got %b expected 0", n, tone_out); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL arst_wrap[%0d]: got %b expected 0", n, wrap); end
    repeat (2) tick();
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++; if (phase !== (step_t'(k - 1) << 28)) begin errors++; $display("FAIL arst_restart[%0d]: got %h expected %h", k, phase, step_t'(k - 1) << 28); end
    end
  endtask

  task automatic test_max_step();
    step_t exp_p;
    logic  exp_w;
    logic  exp_t;
    apply_reset();
    enable    = 1'b1;
    freq_step = 32'hFFFF_FFFF;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp_p = (k == 1) ? '0 : (32'hFFFF_FFFF - step_t'(k - 2));
      exp_w = (k >= 3);
      exp_t = (k >= 2);
      checks++; if (phase !== exp_p) begin errors++; $display("FAIL max_phase[%0d]: got %h expected %h", k, phase, exp_p); end
      checks++; if (wrap !== exp_w) begin errors++; $display("FAIL max_wrap[%0d]: got %b expected %b", k, wrap, exp_w); end
      checks++; if (tone_out !== exp_t) begin errors++; $display("FAIL max_tone[%0d]: got %b expected %b", k, tone_out, exp_t); end
    end
  endtask

`ifdef TONE_BEEP_EN
  task automatic test_beep();
    step_t exp_p;
    logic  on;
    logic  exp_t;
    apply_reset();
    enable    = 1'b1;
    freq_step = 32'h1000_0000;
    for (int i = 1; i <= 140; i++) begin
      tick();
      exp_p = step_t'(i - 1) << 28;
      on    = (i >= 2) && (((i - 2) / 32) % 2 == 0);
      exp_t = exp_p[31] & on;
      checks++; if (phase !== exp_p) begin errors++; $display("FAIL beep_phase[%0d]: got %h expected %h", i, phase, exp_p); end
      checks++; if (tone_out !== exp_t) begin errors++; $display("FAIL beep_tone[%0d]: got %b expected %b", i, tone_out, exp_t); end
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    freq_step = '0;
    #2;
    test_reset();
    test_basic_tone();
    test_mid_change();
    test_zero_step();
    test_enable_carry();
    test_async_reset(8);
    test_async_reset(10);
    test_max_step();
`ifdef TONE_BEEP_EN
    test_beep();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
